// File: rtl/rom_port_arbiter_pkg.sv
// Shared constants for the program ROM read-port arbiter.
//   PORT_I / PORT_D : indices into the per-port request/grant vectors
//   I_NOP           : RV32 canonical NOP (addi x0, x0, 0), same value as
//                     I_NOP in instructions.v; returned to fetch on a bad access
package rom_port_arbiter_pkg;

    localparam int PORT_I = 0;
    localparam int PORT_D = 1;
    localparam int NUM_PORTS = 2;

    localparam logic [31:0] I_NOP = 32'h0000_0013;

endpackage

// File: rtl/rom_resp_slot.sv
// One registered response holding slot.
// Optional macro: ROM_ACCESS_CHECK_EN adds the load_err / resp_err bit.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   load, load_data   : capture a new word at the next rising edge
//   load_err          : error flag captured with the word (macro only)
//   resp_ready        : consumer takes the current response
//   resp_valid/data   : held response
//   resp_err          : held error flag (macro only)
//   slot_free         : slot can accept a grant this cycle
module rom_resp_slot #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
`ifdef ROM_ACCESS_CHECK_EN
    input  logic              load_err,
    output logic              resp_err,
`endif
    input  logic              resp_ready,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_data,
    output logic              slot_free
);

    // Free when empty, or when the current word leaves this same cycle.
    assign slot_free = !resp_valid || resp_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            resp_valid <= 1'b0;
            resp_data  <= '0;
`ifdef ROM_ACCESS_CHECK_EN
            resp_err   <= 1'b0;
`endif
        end else if (load) begin
            // Load wins over consume so back-to-back grants keep valid high.
            resp_valid <= 1'b1;
            resp_data  <= load_data;
`ifdef ROM_ACCESS_CHECK_EN
            resp_err   <= load_err;
`endif
        end else if (resp_valid && resp_ready) begin
            resp_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/rom_port_arbiter.sv
// Shares the combinational program ROM read port between instruction fetch
// (port I) and data load (port D). At most one grant per cycle; responses
// are registered and appear exactly one cycle after the grant.
// Optional macro: ROM_ACCESS_CHECK_EN adds i_resp_err / d_resp_err and the
// ROM_WORDS parameter (misaligned or out-of-range word addresses flag error).
// Ports:
//   clk, reset                         : clock, synchronous active-high reset
//   i_req_valid/ready/addr             : fetch request handshake
//   i_resp_valid/ready/data (/err)     : fetch response handshake
//   d_req_valid/ready/addr             : load request handshake
//   d_resp_valid/ready/data (/err)     : load response handshake
//   rom_addr, rom_data                 : program_rom address / data bus
module rom_port_arbiter
    import rom_port_arbiter_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
`ifdef ROM_ACCESS_CHECK_EN
    ,
    parameter int ROM_WORDS    = 100
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req_valid,
    output logic              i_req_ready,
    input  logic [ADDR_W-1:0] i_req_addr,
    output logic              i_resp_valid,
    input  logic              i_resp_ready,
    output logic [DATA_W-1:0] i_resp_data,
    input  logic              d_req_valid,
    output logic              d_req_ready,
    input  logic [ADDR_W-1:0] d_req_addr,
    output logic              d_resp_valid,
    input  logic              d_resp_ready,
    output logic [DATA_W-1:0] d_resp_data,
`ifdef ROM_ACCESS_CHECK_EN
    output logic              i_resp_err,
    output logic              d_resp_err,
`endif
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data
);

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    logic [NUM_PORTS-1:0] slot_free;
    logic [NUM_PORTS-1:0] eligible;
    logic [NUM_PORTS-1:0] grant;
    logic [3:0]           starve_cnt;
    logic                 force_i;
    logic [DATA_W-1:0]    i_load_data;
    logic [DATA_W-1:0]    d_load_data;

    assign eligible[PORT_I] = i_req_valid && slot_free[PORT_I];
    assign eligible[PORT_D] = d_req_valid && slot_free[PORT_D];
    assign force_i          = (starve_cnt == STARVE_MAX);

    always_comb begin
        grant = '0;
        if (!reset) begin
            if (eligible[PORT_I] && (!eligible[PORT_D] || force_i)) begin
                grant[PORT_I] = 1'b1;
            end else if (eligible[PORT_D]) begin
                grant[PORT_D] = 1'b1;
            end
        end
    end

    assign i_req_ready = grant[PORT_I];
    assign d_req_ready = grant[PORT_D];
    assign rom_addr    = grant[PORT_D] ? d_req_addr : i_req_addr;

    // Counts consecutive cycles where fetch was eligible but lost to D.
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (grant[PORT_I] || !eligible[PORT_I]) begin
            starve_cnt <= '0;
        end else if (starve_cnt != STARVE_MAX) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

`ifdef ROM_ACCESS_CHECK_EN
    logic addr_err;

    // Only the granted address reaches rom_addr, so one check serves both ports.
    assign addr_err    = (rom_addr[1:0] != 2'b00) ||
                         ((rom_addr >> 2) >= ADDR_W'(ROM_WORDS));
    assign i_load_data = addr_err ? DATA_W'(I_NOP) : rom_data;
    assign d_load_data = addr_err ? '0 : rom_data;
`else
    assign i_load_data = rom_data;
    assign d_load_data = rom_data;
`endif

    rom_resp_slot #(.DATA_W(DATA_W)) u_i_slot (
        .clk        (clk),
        .reset      (reset),
        .load       (grant[PORT_I]),
        .load_data  (i_load_data),
`ifdef ROM_ACCESS_CHECK_EN
        .load_err   (addr_err),
        .resp_err   (i_resp_err),
`endif
        .resp_ready (i_resp_ready),
        .resp_valid (i_resp_valid),
        .resp_data  (i_resp_data),
        .slot_free  (slot_free[PORT_I])
    );

    rom_resp_slot #(.DATA_W(DATA_W)) u_d_slot (
        .clk        (clk),
        .reset      (reset),
        .load       (grant[PORT_D]),
        .load_data  (d_load_data),
`ifdef ROM_ACCESS_CHECK_EN
        .load_err   (addr_err),
        .resp_err   (d_resp_err),
`endif
        .resp_ready (d_resp_ready),
        .resp_valid (d_resp_valid),
        .resp_data  (d_resp_data),
        .slot_free  (slot_free[PORT_D])
    );

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Directed bench for rom_port_arbiter. The ROM model returns
// 32'hC0DE_0000 | word_index, so mem[k] = 32'hC0DE_0000 + k.
module tb_rom_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req_valid, i_req_ready, i_resp_valid, i_resp_ready;
    logic        d_req_valid, d_req_ready, d_resp_valid, d_resp_ready;
    logic [31:0] i_req_addr, d_req_addr, i_resp_data, d_resp_data;
    logic [31:0] rom_addr, rom_data;
`ifdef ROM_ACCESS_CHECK_EN
    logic        i_resp_err, d_resp_err;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign rom_data = 32'hC0DE_0000 | (rom_addr >> 2);

    rom_port_arbiter dut (
        .clk          (clk),
        .reset        (reset),
        .i_req_valid  (i_req_valid),
        .i_req_ready  (i_req_ready),
        .i_req_addr   (i_req_addr),
        .i_resp_valid (i_resp_valid),
        .i_resp_ready (i_resp_ready),
        .i_resp_data  (i_resp_data),
        .d_req_valid  (d_req_valid),
        .d_req_ready  (d_req_ready),
        .d_req_addr   (d_req_addr),
        .d_resp_valid (d_resp_valid),
        .d_resp_ready (d_resp_ready),
        .d_resp_data  (d_resp_data),
`ifdef ROM_ACCESS_CHECK_EN
        .i_resp_err   (i_resp_err),
        .d_resp_err   (d_resp_err),
`endif
        .rom_addr     (rom_addr),
        .rom_data     (rom_data)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic exp_i;
        reset        = 1'b1;
        i_req_valid  = 1'b0;
        i_req_addr   = '0;
        i_resp_ready = 1'b0;
        d_req_valid  = 1'b0;
        d_req_addr   = '0;
        d_resp_ready = 1'b0;

        // Requests during reset are refused.
        #1;
        i_req_valid = 1'b1;
        d_req_valid = 1'b1;
        #1;
        check("rst_i_ready", i_req_ready, 0);
        check("rst_d_ready", d_req_ready, 0);
        tick();
        tick();
        check("rst_i_valid", i_resp_valid, 0);
        check("rst_d_valid", d_resp_valid, 0);
        check("rst_i_data",  i_resp_data, 0);
        check("rst_d_data",  d_resp_data, 0);
        reset       = 1'b0;
        i_req_valid = 1'b0;
        d_req_valid = 1'b0;
        tick();

        // Fetch only, back-to-back.
        i_resp_ready = 1'b1;
        d_resp_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            i_req_valid = 1'b1;
            i_req_addr  = 32'(4 * k);
            #1;
            check("fetch_ready", i_req_ready, 1);
            check("fetch_rom_addr", rom_addr, 32'(4 * k));
            tick();
            check("fetch_valid", i_resp_valid, 1);
            check("fetch_data", i_resp_data, 32'hC0DE_0000 + 32'(k));
        end
        i_req_valid = 1'b0;
        tick();
        check("fetch_drop", i_resp_valid, 0);

        // Conflict: D wins 4 cycles, I forced on the 5th.
        for (int n = 0; n < 10; n++) begin
            exp_i       = ((n % 5) == 4);
            i_req_valid = 1'b1;
            d_req_valid = 1'b1;
            i_req_addr  = 32'(4 * (n + 32));
            d_req_addr  = 32'(4 * (n + 64));
            #1;
            check("conf_i_ready", i_req_ready, 32'(exp_i));
            check("conf_d_ready", d_req_ready, 32'(!exp_i));
            tick();
            check("conf_i_valid", i_resp_valid, 32'(exp_i));
            check("conf_d_valid", d_resp_valid, 32'(!exp_i));
            if (exp_i) check("conf_i_data", i_resp_data, 32'hC0DE_0000 + 32'(n + 32));
            else       check("conf_d_data", d_resp_data, 32'hC0DE_0000 + 32'(n + 64));
        end

        // Backpressure on D.
        i_req_valid  = 1'b0;
        d_req_valid  = 1'b1;
        d_req_addr   = 32'd16;
        d_resp_ready = 1'b0;
        #1;
        check("bp_d_grant", d_req_ready, 1);
        tick();
        check("bp_d_valid0", d_resp_valid, 1);
        check("bp_d_data0", d_resp_data, 32'hC0DE_0004);
        for (int k = 0; k < 3; k++) begin
            d_req_addr  = 32'd24;
            i_req_valid = 1'b1;
            i_req_addr  = 32'(4 * (k + 40));
            #1;
            check("bp_d_ready", d_req_ready, 0);
            check("bp_i_ready", i_req_ready, 1);
            tick();
            check("bp_d_valid", d_resp_valid, 1);
            check("bp_d_hold", d_resp_data, 32'hC0DE_0004);
            check("bp_i_data", i_resp_data, 32'hC0DE_0000 + 32'(k + 40));
        end

        // Same-cycle consume and new grant on D.
        i_req_valid  = 1'b0;
        d_resp_ready = 1'b1;
        d_req_addr   = 32'd20;
        #1;
        check("cg_d_ready", d_req_ready, 1);
        tick();
        check("cg_d_valid", d_resp_valid, 1);
        check("cg_d_data", d_resp_data, 32'hC0DE_0005);
        d_req_valid = 1'b0;
        tick();
        check("cg_d_drop", d_resp_valid, 0);
        check("cg_i_drop", i_resp_valid, 0);

        // Reset with both responses pending.
        d_resp_ready = 1'b0;
        i_resp_ready = 1'b0;
        d_req_valid  = 1'b1;
        d_req_addr   = 32'd8;
        tick();
        d_req_valid  = 1'b0;
        i_req_valid  = 1'b1;
        i_req_addr   = 32'd12;
        tick();
        check("pend_i_valid", i_resp_valid, 1);
        check("pend_d_valid", d_resp_valid, 1);
        reset = 1'b1;
        #1;
        check("midrst_i_ready", i_req_ready, 0);
        tick();
        check("midrst_i_valid", i_resp_valid, 0);
        check("midrst_d_valid", d_resp_valid, 0);
        check("midrst_i_data", i_resp_data, 0);
        reset = 1'b0;

        // Build starvation to 3, reset, then the full D,D,D,D,I pattern must return.
        i_resp_ready = 1'b1;
        d_resp_ready = 1'b1;
        d_req_valid  = 1'b1;
        i_req_addr   = 32'd0;
        d_req_addr   = 32'd4;
        for (int k = 0; k < 3; k++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int n = 0; n < 5; n++) begin
            exp_i      = (n == 4);
            d_req_addr = 32'(4 * (n + 8));
            #1;
            check("post_i_ready", i_req_ready, 32'(exp_i));
            check("post_d_ready", d_req_ready, 32'(!exp_i));
            tick();
            if (n == 0) begin
                check("post_lat_valid", d_resp_valid, 1);
                check("post_lat_data", d_resp_data, 32'hC0DE_0008);
            end
        end
        i_req_valid = 1'b0;
        d_req_valid = 1'b0;
        tick();

`ifdef ROM_ACCESS_CHECK_EN
        i_req_valid = 1'b1;
        i_req_addr  = 32'd6;
        tick();
        i_req_valid = 1'b0;
        check("err_i_flag", i_resp_err, 1);
        check("err_i_data", i_resp_data, 32'h0000_0013);
        d_req_valid = 1'b1;
        d_req_addr  = 32'd400;
        tick();
        check("err_d_flag", d_resp_err, 1);
        check("err_d_data", d_resp_data, 0);
        d_req_addr  = 32'd12;
        tick();
        d_req_valid = 1'b0;
        check("ok_d_flag", d_resp_err, 0);
        check("ok_d_data", d_resp_data, 32'hC0DE_0003);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rom_port_arbiter.md
Name: rom_port_arbiter

Overview:
Shares the single combinational read port of the program ROM between two requesters: instruction fetch (port I) and data load (port D, for loads from the constant/ROM space).
- Grants at most one request per cycle and drives the ROM address from the winner.
- Captures the ROM word into a per-port response register, so responses appear one cycle after grant.
- Sits between the RV32E core's fetch/LSU and program_rom.

Parameters:
- ADDR_W, 32, byte address width.
- DATA_W, 32, ROM word width.
- STARVE_LIMIT, 4, consecutive cycles port I may lose arbitration before it is forced to win (range 1..15).
- ROM_WORDS, 100, number of implemented ROM words, used only by the optional check.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- i_req_valid  input  1  fetch request valid.
- i_req_ready  output  1  fetch request accepted this cycle.
- i_req_addr  input  ADDR_W  fetch byte address.
- i_resp_valid  output  1  fetch response valid.
- i_resp_ready  input  1  fetch consumer takes the response.
- i_resp_data  output  DATA_W  fetched word.
- d_req_valid  input  1  load request valid.
- d_req_ready  output  1  load request accepted.
- d_req_addr  input  ADDR_W  load byte address.
- d_resp_valid  output  1  load response valid.
- d_resp_ready  input  1  load consumer takes the response.
- d_resp_data  output  DATA_W  loaded word.
- rom_addr  output  ADDR_W  address to program_rom addr_bus.
- rom_data  input  DATA_W  program_rom data_bus (combinational).
- i_resp_err  output  1  present only with ROM_ACCESS_CHECK_EN.
- d_resp_err  output  1  present only with ROM_ACCESS_CHECK_EN.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: all *_resp_valid = 0, *_resp_data = 0, starve counter = 0, *_resp_err = 0.
- Eligibility: port X may be granted when X_req_valid is high and its response slot is free. The slot is free when X_resp_valid = 0, or when X_resp_valid = 1 and X_resp_ready = 1 in the same cycle.
- Priority: D beats I, unless starve_cnt == STARVE_LIMIT, in which case I wins.
- Starve counter:
  - Increments (saturating at STARVE_LIMIT) when I is eligible but D is granted.
  - Clears to 0 when I is granted or I is not eligible.
- Outputs of the grant:
  - X_req_ready is combinational and equals grant_X.
  - rom_addr = the granted address, or i_req_addr when there is no grant.
- Response timing:
  - On grant_X, the response register loads rom_data at the clock edge and X_resp_valid = 1 the next cycle. Latency is exactly 1 cycle.
  - The response holds stable while X_resp_valid && !X_resp_ready.
  - X_resp_valid drops on consume unless a new grant to X happens in the same cycle (back-to-back throughput 1 per cycle per port).
- Simultaneous events: consume and new grant on the same port in the same cycle gives new data and valid stays 1. A grant to one port never disturbs the other port's response register.
- Address handling: the full byte address goes to the ROM. The ROM aligns it internally; this block does not modify addresses.
- Reset mid-operation: pending responses are discarded, valids go to 0, and the starve counter clears. Requests presented during reset get ready = 0.

Optional Feature:
- Macro: ROM_ACCESS_CHECK_EN.
- When defined:
  - Adds i_resp_err and d_resp_err, registered alongside the data.
  - err = 1 if addr[1:0] != 0 or addr/4 >= ROM_WORDS.
  - On error, resp_data = 0; for port I only, it is forced to 32'h00000013 (NOP).
  - Error flags reset to 0.
- When undefined: the err ports are absent and data is passed through unchecked.

Decomposition:
- Shared package / include: port index constants (PORT_I = 0, PORT_D = 1) and the NOP encoding constant, reusing I_NOP from instructions.v.
- Natural sub-module: rom_resp_slot, one registered response holding slot (load / hold / consume logic, optional err bit), instantiated twice.
- The arbiter and starve counter stay in the top module.

Test Plan:
- Fetch only: I requests addr 0, 4, 8 back-to-back with i_resp_ready = 1 -> i_req_ready = 1 every cycle; i_resp_data = mem[0], mem[1], mem[2], each one cycle later, with valid held continuously.
- Conflict: I and D both valid every cycle, both resp_ready = 1, STARVE_LIMIT = 4 -> D granted 4 cycles, I granted on the 5th, pattern repeats; no response lost.
- Backpressure: d_resp_ready = 0 for 3 cycles after a D grant at addr 16 -> d_resp_data stays mem[4], d_req_ready = 0 for further D requests, I requests still granted.
- Same-cycle consume + grant: D holds a response, d_resp_ready = 1 with a new d_req at addr 20 -> d_req_ready = 1 and next cycle d_resp_data = mem[5] with valid never dropping.
- Reset mid-stream: assert reset while both responses are pending -> next cycle both valids = 0 and the starve counter is 0; the first request after deassert completes with latency 1.
- With ROM_ACCESS_CHECK_EN: I addr 6 -> i_resp_err = 1, data 32'h00000013; D addr 400 -> d_resp_err = 1, data 0; D addr 12 -> err = 0, data mem[3].
